alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Controller that owns the shared 4-bit ALU and sequences operations through it.
- Accepts commands over a valid/ready interface and holds a 4x4-bit operand register file.
- Drives the ALU ports from registers, captures the ALU result and writes it back.
- Sweep mode steps through all 16 {Cin,S} combinations on one operand pair; each result goes out a backpressured result stream.
- Sits between the command source (bench or top-level FSM) and the combinational ALU.

Parameters:
- DW, 4, operand/result width (ALU data width)
- NREG, 4, register file depth (addresses are 2 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00=NOP, 01=LOAD, 10=EXEC, 11=SWEEP
- cmd_sel  in  3  ALU function select for EXEC
- cmd_cin  in  1  ALU carry-in for EXEC
- cmd_ra  in  2  register address for ALU A operand
- cmd_rb  in  2  register address for ALU B operand
- cmd_rd  in  2  destination register (LOAD/EXEC)
- cmd_imm  in  4  immediate for LOAD
- alu_a  out  4  to ALU A
- alu_b  out  4  to ALU B
- alu_s  out  3  to ALU S
- alu_cin  out  1  to ALU Cin
- alu_y  in  4  from ALU Y (combinational)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  4  captured ALU result
- res_tag  out  4  {cin,s} used for this result
- busy  out  1  high whenever state != IDLE
- dbg_addr  in  2  register file read address
- dbg_data  out  4  combinational register file read

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All registers, sweep index and result registers clear to 0.
  - alu_a/b/s/cin = 0, res_valid = 0, res_data = 0, res_tag = 0, busy = 0, cmd_ready = 1.
  - A reset mid-operation aborts immediately; no result is emitted and no writeback occurs.
- cmd_ready = (state==IDLE), combinational. Accept = cmd_valid & cmd_ready at a rising edge.
- States: IDLE, ISSUE, RESULT.
- IDLE, on accept:
  - NOP: no effect; stay IDLE.
  - LOAD: reg[rd] <= imm at the accept edge; stay IDLE.
  - EXEC: alu_a <= reg[ra], alu_b <= reg[rb], alu_s <= sel, alu_cin <= cin (values read at the accept edge); latch rd; go to ISSUE.
  - SWEEP: alu_a <= reg[ra], alu_b <= reg[rb], idx <= 0, alu_s <= 0, alu_cin <= 0; go to ISSUE.
- ISSUE (exactly 1 cycle, ALU settles): at the next edge res_data <= alu_y, res_tag <= {alu_cin,alu_s}, res_valid <= 1; go to RESULT.
- RESULT:
  - res_valid = 1; res_data, res_tag and alu_* are held stable until res_valid & res_ready.
  - On handshake, EXEC: reg[rd] <= res_data, res_valid <= 0, go to IDLE.
  - On handshake, SWEEP with idx != 15: idx <= idx+1, {alu_cin,alu_s} <= idx+1, res_valid <= 0, go to ISSUE. Order is Cin outer (0 then 1), S inner (0..7).
  - On handshake, SWEEP with idx == 15: res_valid <= 0, go to IDLE. Sweep never writes the register file.
- Latency:
  - EXEC accepted at edge E: res_valid is high after edge E+1. With res_ready high, IDLE is reached after edge E+2.
  - Sweep with res_ready tied high: 16 results, one every 2 cycles; busy is high for 32 cycles.
- alu_* outputs are registered and hold their last values in IDLE.
- ra == rb is legal. An EXEC writeback is visible on dbg_data and to the next command on the cycle after the handshake edge.
- Commands presented while busy wait (cmd_ready = 0); cmd fields need only be stable while cmd_valid is high.
- Arithmetic is the ALU's; the sequencer only moves 4-bit values, with no width extension.

Test Plan:
(The bench uses a behavioural ALU stub: Y = (A+B+Cin) mod 16.)
1. Reset: hold rst_n low mid-clock -> immediately cmd_ready=1, busy=0, res_valid=0, alu_a/b/s/cin=0, dbg_data=0 for all 4 addresses.
2. LOAD r0=6, LOAD r1=12, then EXEC sel=3 cin=0 ra=0 rb=1 rd=2 with res_ready=1:
   - ISSUE shows alu_a=6, alu_b=12, alu_s=3, alu_cin=0.
   - res_valid pulses one cycle with res_data=2, res_tag=4'h3.
   - Afterwards dbg_addr=2 -> dbg_data=2.
3. SWEEP ra=0 rb=1 with res_ready=1:
   - 16 results, res_tag 0..15 in order.
   - res_data=2 for tags 0-7, 3 for tags 8-15.
   - busy high for 32 cycles; registers unchanged.
4. Backpressure: during EXEC, hold res_ready=0 for 5 cycles -> res_valid stays 1 and res_data, res_tag and alu_* stay stable. Raising res_ready completes the writeback in one edge.
5. Reset mid-sweep: assert rst_n low when res_tag=5 -> IDLE, res_valid=0, registers=0 at once. After release, LOAD/EXEC as in test 2 reproduces res_data=2.
6. Hold cmd_valid=1 with a LOAD during a sweep -> not accepted until IDLE, then written in one cycle. A NOP is accepted with no register or result change.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences LOAD/EXEC/SWEEP commands through an external 4-bit combinational ALU.
// EXEC result valid one cycle after accept; result held until res_ready, commands stalled while busy.
module alu_op_sequencer #(
  parameter int DW   = 4,
  parameter int NREG = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [2:0]    cmd_sel,
  input  logic          cmd_cin,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic [DW-1:0] cmd_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_s,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [3:0]    res_tag,
  output logic          busy,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESULT} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_EXEC  = 2'b10;
  localparam logic [1:0] OP_SWEEP = 2'b11;

  state_t        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [2:0]    alu_s_q, alu_s_d;
  logic          alu_cin_q, alu_cin_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          sweep_q, sweep_d;
  logic [3:0]    idx_q, idx_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [3:0]    res_tag_q, res_tag_d;
  logic          cmd_accept;

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cmd_accept = cmd_valid & cmd_ready;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_s      = alu_s_q;
  assign alu_cin    = alu_cin_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign dbg_data   = regs_q[dbg_addr];

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    alu_cin_d   = alu_cin_q;
    rd_d        = rd_q;
    sweep_d     = sweep_q;
    idx_d       = idx_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          case (cmd_op)
            OP_LOAD: regs_d[cmd_rd] = cmd_imm;
            OP_EXEC: begin
              alu_a_d   = regs_q[cmd_ra];
              alu_b_d   = regs_q[cmd_rb];
              alu_s_d   = cmd_sel;
              alu_cin_d = cmd_cin;
              rd_d      = cmd_rd;
              sweep_d   = 1'b0;
              state_d   = ISSUE;
            end
            OP_SWEEP: begin
              alu_a_d   = regs_q[cmd_ra];
              alu_b_d   = regs_q[cmd_rb];
              alu_s_d   = 3'd0;
              alu_cin_d = 1'b0;
              idx_d     = 4'd0;
              sweep_d   = 1'b1;
              state_d   = ISSUE;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        res_data_d  = alu_y;
        res_tag_d   = {alu_cin_q, alu_s_q};
        res_valid_d = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!sweep_q) begin
            regs_d[rd_q] = res_data_q;
            state_d      = IDLE;
          end else if (idx_q != 4'hF) begin
            // idx doubles as {cin,s}: Cin is the outer loop, S the inner.
            idx_d                  = idx_q + 4'd1;
            {alu_cin_d, alu_s_d}   = idx_q + 4'd1;
            state_d                = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      alu_cin_q   <= 1'b0;
      rd_q        <= '0;
      sweep_q     <= 1'b0;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      alu_cin_q   <= alu_cin_d;
      rd_q        <= rd_d;
      sweep_q     <= sweep_d;
      idx_q       <= idx_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with an adder-style ALU stub (Y = A+B+Cin mod 16).
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_cin;
  logic [1:0] cmd_op, cmd_ra, cmd_rb, cmd_rd, dbg_addr;
  logic [2:0] cmd_sel, alu_s;
  logic [3:0] cmd_imm, alu_a, alu_b, alu_y, res_data, res_tag, dbg_data;
  logic       alu_cin, res_valid, res_ready, busy;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] tag;
    logic       wb;
    logic [1:0] rd;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] model_regs [4];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         waited;

  always #5 clk = ~clk;

  assign alu_y = alu_a + alu_b + {3'b000, alu_cin};

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_cin(cmd_cin), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every handshaken result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("res_data", res_data, e.data);
        check_eq("res_tag", res_tag, e.tag);
        if (e.wb) model_regs[e.rd] = e.data;
      end
    end
  end

  task automatic check_regs(input string tag);
    for (int a = 0; a < 4; a++) begin
      dbg_addr = a[1:0];
      #1;
      check_eq(tag, dbg_data, model_regs[a]);
    end
  endtask

  // Drives one command, holds it until accepted; returns negedges spent waiting.
  task automatic send_cmd(input logic [1:0] op, input logic [2:0] sel, input logic cin,
                          input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                          input logic [3:0] imm, output int wait_cnt);
    exp_t e;
    cmd_op = op; cmd_sel = sel; cmd_cin = cin; cmd_ra = ra; cmd_rb = rb;
    cmd_rd = rd; cmd_imm = imm; cmd_valid = 1'b1;
    wait_cnt = 0;
    if (op == 2'b10) begin
      e.data = model_regs[ra] + model_regs[rb] + {3'b000, cin};
      e.tag  = {cin, sel};
      e.wb   = 1'b1;
      e.rd   = rd;
      sb_q.push_back(e);
    end else if (op == 2'b11) begin
      for (int t = 0; t < 16; t++) begin
        e.tag  = t[3:0];
        e.data = model_regs[ra] + model_regs[rb] + {3'b000, e.tag[3]};
        e.wb   = 1'b0;
        e.rd   = 2'd0;
        sb_q.push_back(e);
      end
    end
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      wait_cnt++;
      if (wait_cnt > 200) begin
        check_eq("cmd_accept_timeout", wait_cnt, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (op == 2'b01) model_regs[rd] = imm;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        check_eq(tag, n, 0);
        break;
      end
    end
  endtask

  task automatic load_and_exec();
    send_cmd(2'b01, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd6, waited);
    send_cmd(2'b01, 3'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd12, waited);
    send_cmd(2'b10, 3'd3, 1'b0, 2'd0, 2'd1, 2'd2, 4'd0, waited);
  endtask

  initial begin
    int busy_cnt;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sel = 3'd0; cmd_cin = 1'b0;
    cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_rd = 2'd0; cmd_imm = 4'd0; res_ready = 1'b1; dbg_addr = 2'd0;
    for (int i = 0; i < 4; i++) model_regs[i] = 4'd0;

    // 1: asynchronous reset mid-clock
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_alu", {alu_a, alu_b, alu_s, alu_cin}, 0);
    check_regs("rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: LOAD/LOAD/EXEC with immediate acceptance of the result
    load_and_exec();
    @(negedge clk);
    check_eq("issue_alu_a", alu_a, 6);
    check_eq("issue_alu_b", alu_b, 12);
    check_eq("issue_alu_s", alu_s, 3);
    check_eq("issue_alu_cin", alu_cin, 0);
    check_eq("issue_res_valid", res_valid, 0);
    @(negedge clk);
    check_eq("exec_res_valid", res_valid, 1);
    check_eq("exec_res_data", res_data, 2);
    check_eq("exec_res_tag", res_tag, 3);
    @(negedge clk);
    check_eq("exec_pulse_end", res_valid, 0);
    check_eq("exec_idle", busy, 0);
    dbg_addr = 2'd2;
    #1;
    check_eq("exec_wb", dbg_data, 2);

    // 3: full sweep with res_ready tied high
    @(posedge clk);
    #1;
    send_cmd(2'b11, 3'd0, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, waited);
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (busy_cnt > 100) break;
    end
    check_eq("sweep_busy_cycles", busy_cnt, 32);
    check_eq("sweep_sb_drained", sb_q.size(), 0);
    check_regs("sweep_reg");

    // 4: backpressure on an EXEC result
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    send_cmd(2'b10, 3'd5, 1'b1, 2'd0, 2'd1, 2'd3, 4'd0, waited);
    wait_res("bp_res_timeout");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("bp_res_valid", res_valid, 1);
      check_eq("bp_res_data", res_data, 3);
      check_eq("bp_res_tag", res_tag, 4'hD);
      check_eq("bp_alu", {alu_a, alu_b, alu_s, alu_cin}, {4'd6, 4'd12, 3'd5, 1'b1});
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_done_valid", res_valid, 0);
    check_eq("bp_done_busy", busy, 0);
    dbg_addr = 2'd3;
    #1;
    check_eq("bp_wb", dbg_data, 3);

    // 5: reset in the middle of a sweep
    @(posedge clk);
    #1;
    send_cmd(2'b11, 3'd0, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, waited);
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        if (res_valid && res_tag == 4'd5) break;
        n++;
        if (n > 40) begin
          check_eq("midsweep_timeout", n, 0);
          break;
        end
      end
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_regs[i] = 4'd0;
    check_eq("mid_rst_res_valid", res_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_cmd_ready", cmd_ready, 1);
    check_eq("mid_rst_sb_left", sb_q.size(), 10);
    sb_q.delete();
    check_regs("mid_rst_reg");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_and_exec();
    wait_res("post_rst_res_timeout");
    check_eq("post_rst_res_data", res_data, 2);
    @(negedge clk);
    @(negedge clk);

    // 6: LOAD held during a sweep, then a NOP
    @(posedge clk);
    #1;
    send_cmd(2'b11, 3'd0, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, waited);
    send_cmd(2'b01, 3'd0, 1'b0, 2'd0, 2'd0, 2'd3, 4'd9, waited);
    check_eq("held_load_wait", waited, 32);
    check_eq("held_load_sb_drained", sb_q.size(), 0);
    @(negedge clk);
    dbg_addr = 2'd3;
    #1;
    check_eq("held_load_wb", dbg_data, 9);
    @(posedge clk);
    #1;
    send_cmd(2'b00, 3'd0, 1'b0, 2'd0, 2'd0, 2'd3, 4'hF, waited);
    @(negedge clk);
    check_eq("nop_res_valid", res_valid, 0);
    check_eq("nop_busy", busy, 0);
    check_regs("nop_reg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
